// File: rtl/forest_pkg.sv
// forest_pkg
//   Shared defaults and types for the forest vote argmax stage.
//   NUM_CLASSES_DEF / NUM_TREES_DEF : default class and tree counts.
//   CW_DEF / VW_DEF                 : class-index and score widths derived from them.
//   state_e                         : controller state encoding (ACC, HOLD).
package forest_pkg;

    localparam int NUM_CLASSES_DEF = 6;
    localparam int NUM_TREES_DEF   = 8;
    localparam int CW_DEF          = $clog2(NUM_CLASSES_DEF);
    localparam int VW_DEF          = $clog2(NUM_TREES_DEF + 1);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/vote_popcount.sv
// vote_popcount
//   Combinational population count of one beat of tree votes.
//   votes_i : NUM_TREES tree outputs for one class.
//   count_o : number of set bits, 0..NUM_TREES, VW bits wide.
module vote_popcount #(
    parameter  int NUM_TREES = 8,
    localparam int VW        = $clog2(NUM_TREES + 1)
) (
    input  logic [NUM_TREES-1:0] votes_i,
    output logic [VW-1:0]        count_o
);

    // VW is sized so NUM_TREES itself fits, so the running sum cannot overflow.
    always_comb begin
        count_o = '0;
        for (int t = 0; t < NUM_TREES; t++) begin
            count_o = count_o + VW'(votes_i[t]);
        end
    end

endmodule

// File: rtl/forest_vote_argmax.sv
// forest_vote_argmax
//   Collects one vote beat per class (classes in order 0..NUM_CLASSES-1),
//   popcounts each beat, tracks the running maximum and presents the winner.
//   clk, rst_n          : clock, asynchronous active-low reset.
//   in_valid/in_ready   : beat handshake; in_votes carries the current class votes.
//   out_valid/out_ready : result handshake.
//   out_class/out_score : winning class index and its vote count.
//   out_tie             : another class reached the same maximum score.
//
//   state   | meaning
//   --------+-------------------------------------------
//   ST_ACC  | accepting class beats, in_ready high
//   ST_HOLD | result presented, waiting for out_ready
module forest_vote_argmax
    import forest_pkg::*;
#(
    parameter  int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter  int NUM_TREES   = NUM_TREES_DEF,
    localparam int CW          = $clog2(NUM_CLASSES),
    localparam int VW          = $clog2(NUM_TREES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_TREES-1:0] in_votes,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_class,
    output logic [VW-1:0]        out_score,
    output logic                 out_tie
);

    localparam logic [CW-1:0] LAST_CLASS = CW'(NUM_CLASSES - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   best_score_q, best_score_d;
    logic [CW-1:0]   best_class_q, best_class_d;
    logic            tie_q, tie_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   out_class_q, out_class_d;
    logic [VW-1:0]   out_score_q, out_score_d;
    logic            out_tie_q, out_tie_d;

    logic [VW-1:0]   beat_score;
    logic [VW-1:0]   upd_score;
    logic [CW-1:0]   upd_class;
    logic            upd_tie;

    vote_popcount #(
        .NUM_TREES (NUM_TREES)
    ) u_popcount (
        .votes_i (in_votes),
        .count_o (beat_score)
    );

    // Running argmax after folding in the current beat. Class 0 reseeds the
    // accumulators so nothing from the previous sample leaks in; on equal
    // scores the stored (lower) index is kept and only the tie flag is set.
    always_comb begin
        upd_score = best_score_q;
        upd_class = best_class_q;
        upd_tie   = tie_q;
        if (cnt_q == '0) begin
            upd_score = beat_score;
            upd_class = '0;
            upd_tie   = 1'b0;
        end else if (beat_score > best_score_q) begin
            upd_score = beat_score;
            upd_class = cnt_q;
            upd_tie   = 1'b0;
        end else if (beat_score == best_score_q) begin
            upd_tie   = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        best_score_d = best_score_q;
        best_class_d = best_class_q;
        tie_d        = tie_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_class_d  = out_class_q;
        out_score_d  = out_score_q;
        out_tie_d    = out_tie_q;

        case (state_q)
            ST_ACC: begin
                // in_ready comes up one edge after reset release and stays up in ACC.
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    best_score_d = upd_score;
                    best_class_d = upd_class;
                    tie_d        = upd_tie;
                    if (cnt_q == LAST_CLASS) begin
                        cnt_d       = '0;
                        out_class_d = upd_class;
                        out_score_d = upd_score;
                        out_tie_d   = upd_tie;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        state_d     = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                in_ready_d = 1'b0;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_ACC;
                end
            end
            default: begin
                state_d    = ST_ACC;
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ACC;
            cnt_q        <= '0;
            best_score_q <= '0;
            best_class_q <= '0;
            tie_q        <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_class_q  <= '0;
            out_score_q  <= '0;
            out_tie_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            best_score_q <= best_score_d;
            best_class_q <= best_class_d;
            tie_q        <= tie_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_class_q  <= out_class_d;
            out_score_q  <= out_score_d;
            out_tie_q    <= out_tie_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_score = out_score_q;
    assign out_tie   = out_tie_q;

endmodule

// File: tb/tb_forest_vote_argmax.sv
// tb_forest_vote_argmax
//   Directed vectors plus a randomized-stall run against a small reference
//   model for forest_vote_argmax with default parameters (6 classes, 8 trees).
module tb_forest_vote_argmax;

    localparam int NC = 6;
    localparam int NT = 8;
    localparam int N_RAND = 1000;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NT-1:0] in_votes;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_class;
    logic [3:0]    out_score;
    logic          out_tie;

    int n_chk;
    int n_pass;

    forest_vote_argmax dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_votes  (in_votes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score),
        .out_tie   (out_tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [NT-1:0] v);
        int budget;
        budget = 0;
        in_valid = 1'b1;
        in_votes = v;
        while (!in_ready && budget < 200) begin
            tick();
            budget++;
        end
        if (budget >= 200) chk("beat_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [NT-1:0] v0, v1, v2, v3, v4, v5);
        send_beat(v0); send_beat(v1); send_beat(v2);
        send_beat(v3); send_beat(v4); send_beat(v5);
    endtask

    task automatic check_res(input string tag, input int cls, input int sc, input int tie);
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_class"}, int'(out_class), cls);
        chk({tag, "_score"}, int'(out_score), sc);
        chk({tag, "_tie"},   int'(out_tie),   tie);
    endtask

    // Reference: scores by $countones, winner = first index holding the
    // overall maximum, tie = maximum reached by more than one class.
    function automatic int model(input logic [NT-1:0] v [NC]);
        int sc [NC];
        int mx, cls, nmax;
        mx = 0;
        for (int c = 0; c < NC; c++) begin
            sc[c] = $countones(v[c]);
            if (sc[c] > mx) mx = sc[c];
        end
        cls = -1;
        nmax = 0;
        for (int c = 0; c < NC; c++) begin
            if (sc[c] == mx) begin
                nmax++;
                if (cls < 0) cls = c;
            end
        end
        return (cls << 5) | (mx << 1) | ((nmax > 1) ? 1 : 0);
    endfunction

    int exp_q [$];
    int n_in, n_out;

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_votes = '0;
        out_ready = 1'b0;

        // Reset and release
        tick(); tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_class", int'(out_class), 0);
        chk("rst_out_score", int'(out_score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_early", int'(in_ready), 0);
        tick();
        chk("rel_in_ready", int'(in_ready), 1);
        tick(); tick();
        chk("idle_out_valid", int'(out_valid), 0);

        // Single clear winner: class 3 with all 8 votes
        out_ready = 1'b1;
        send_sample(8'h01, 8'h0F, 8'h03, 8'hFF, 8'h00, 8'h07);
        check_res("clear", 3, 8, 0);
        chk("clear_in_ready_low", int'(in_ready), 0);
        tick();
        chk("clear_ov_drop", int'(out_valid), 0);
        chk("clear_in_ready_up", int'(in_ready), 1);

        // Scores 2,5,5,1,0,5: lowest index wins, tie flagged
        send_sample(8'h03, 8'h1F, 8'hF8, 8'h80, 8'h00, 8'h7C);
        check_res("tie", 1, 5, 1);
        tick();

        // Result held with out_ready low while upstream keeps presenting FF
        out_ready = 1'b0;
        send_sample(8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F);
        check_res("stall", 5, 6, 0);
        begin
            int stable;
            stable = 1;
            in_valid = 1'b1;
            in_votes = 8'hFF;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_class !== 3'd5 ||
                    out_score !== 4'd6 || out_tie !== 1'b0) stable = 0;
            end
            chk("stall_stable", stable, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_ov_drop", int'(out_valid), 0);
        chk("stall_in_ready_up", int'(in_ready), 1);
        chk("stall_class_kept", int'(out_class), 5);
        chk("stall_score_kept", int'(out_score), 6);
        send_sample(8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01);
        check_res("after_stall", 0, 6, 0);
        tick();

        // All classes silent
        send_sample(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check_res("zero", 0, 0, 1);
        tick();

        // Reset in the middle of a sample
        send_beat(8'hFF); send_beat(8'hFF); send_beat(8'hFF);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst_rel_in_ready", int'(in_ready), 1);
        send_sample(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10);
        check_res("midrst", 5, 1, 0);
        tick();

        // Random stalls on both sides against the reference model
        n_in = 0;
        n_out = 0;
        fork
            begin
                logic [NT-1:0] v [NC];
                for (int s = 0; s < N_RAND; s++) begin
                    for (int c = 0; c < NC; c++) begin
                        v[c] = NT'($urandom_range(0, 255));
                        if ($urandom_range(0, 3) == 0) v[c] = v[c] & 8'h0F;
                    end
                    exp_q.push_back(model(v));
                    n_in++;
                    for (int c = 0; c < NC; c++) begin
                        int gap;
                        gap = $urandom_range(0, 2);
                        for (int g = 0; g < gap; g++) tick();
                        send_beat(v[c]);
                    end
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (n_out < N_RAND && cyc < 60000) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    cyc++;
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("rnd_unexpected", 1, 0);
                        end else begin
                            chk("rnd_result", int'({out_class, out_score, out_tie}), exp_q.pop_front());
                        end
                        n_out++;
                    end
                end
                if (cyc >= 60000) chk("rnd_timeout", 0, 1);
            end
        join
        chk("rnd_count", n_out, n_in);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
